// File: rtl/apa102_frame_tx_if.sv
// -----------------------------------------------------------------------------
// apa102_frame_tx_if
// Byte handshake between the APA102 frame sequencer and the byte-wide SPI
// master.
//   spi_start : one-cycle request to send spi_data
//   spi_data  : byte to send, held until spi_done
//   spi_size  : transfer width in bits (always 8)
//   spi_done  : one-cycle completion pulse from the SPI master
// modport master : the sequencer side (drives start/data/size)
// modport slave  : the SPI master side (drives done)
// -----------------------------------------------------------------------------
interface apa102_frame_tx_if;
    logic       spi_start;
    logic [7:0] spi_data;
    logic [3:0] spi_size;
    logic       spi_done;

    modport master (output spi_start, output spi_data, output spi_size, input spi_done);
    modport slave  (input spi_start, input spi_data, input spi_size, output spi_done);
endinterface

// File: rtl/apa102_frame_tx.sv
// -----------------------------------------------------------------------------
// apa102_frame_tx
// On each accepted frame request, streams one full APA102 frame to the SPI
// master: 4 x 0x00 start bytes, {111,brightness},B,G,R per LED read from the
// pixel RAM, then END_BYTES x 0xFF.
// Ports:
//   module_clk, rst : clock, asynchronous active-high reset
//   frame_start     : frame request, only looked at while idle
//   brightness      : 5-bit global brightness, latched at frame acceptance
//   pix_addr        : pixel RAM read address (held between fetches)
//   pix_data        : pixel RAM read data {R,G,B}, one cycle after pix_addr
//   spi             : byte handshake to the SPI master (master modport)
//   busy            : frame in progress
//   frame_done      : one-cycle pulse on frame completion
//   timeout_err     : sticky abort flag, cleared by the next accepted frame
// -----------------------------------------------------------------------------
module apa102_frame_tx #(
    parameter  int NUM_LEDS = 16,
    parameter  int TIMEOUT  = 4096,
    localparam int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  module_clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [4:0]            brightness,
    output logic [ADDR_W-1:0]     pix_addr,
    input  logic [23:0]           pix_data,
    apa102_frame_tx_if.master     spi,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  timeout_err
);
    localparam int EB_RAW    = (NUM_LEDS + 15) / 16;
    localparam int END_BYTES = (EB_RAW > 4) ? EB_RAW : 4;
    localparam int CNT_W     = $clog2(END_BYTES);   // END_BYTES >= 4, so >= 2 bits
    localparam int TO_W      = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;
    typedef enum logic [1:0] {P_START, P_LED, P_END} phase_t;

    state_t            state, state_n;
    phase_t            phase, phase_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [TO_W-1:0]   wait_cnt;
    logic [4:0]        bri_q;
    logic [23:0]       pix_q;
    logic              fetch_q;
    logic              fin, abort, accept;

    assign accept = (state == S_IDLE) && frame_start;

    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt;
        idx_n   = idx;
        fin     = 1'b0;
        abort   = 1'b0;
        case (state)
            S_IDLE: if (frame_start) begin
                state_n = S_SEND;
                phase_n = P_START;
                cnt_n   = '0;
                idx_n   = '0;
            end
            S_SEND: state_n = S_WAIT;
            S_WAIT: begin
                if (spi.spi_done) begin
                    state_n = S_SEND;
                    case (phase)
                        P_START: begin
                            if (cnt == CNT_W'(3)) begin
                                phase_n = P_LED;
                                cnt_n   = '0;
                            end else begin
                                cnt_n = cnt + 1'b1;
                            end
                        end
                        P_LED: begin
                            if (cnt == CNT_W'(3)) begin
                                cnt_n = '0;
                                if (idx == ADDR_W'(NUM_LEDS - 1)) phase_n = P_END;
                                else                              idx_n   = idx + 1'b1;
                            end else begin
                                cnt_n = cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (cnt == CNT_W'(END_BYTES - 1)) begin
                                state_n = S_IDLE;
                                phase_n = P_START;
                                cnt_n   = '0;
                                fin     = 1'b1;
                            end else begin
                                cnt_n = cnt + 1'b1;
                            end
                        end
                    endcase
                end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_n = S_IDLE;
                    phase_n = P_START;
                    cnt_n   = '0;
                    abort   = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge module_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            phase       <= P_START;
            cnt         <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
            bri_q       <= '0;
            pix_q       <= '0;
            fetch_q     <= 1'b0;
            pix_addr    <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            frame_done <= fin;
            // Counts WAIT cycles; SEND (and IDLE) hold it at zero.
            wait_cnt   <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (accept) bri_q <= brightness;
            if (abort)       timeout_err <= 1'b1;
            else if (accept) timeout_err <= 1'b0;
            // Address goes out alongside the header SEND; the RAM answers in
            // the following WAIT cycle, captured one edge later, well before
            // the B byte can be driven.
            if (state_n == S_SEND && phase_n == P_LED && cnt_n == '0) pix_addr <= idx_n;
            fetch_q <= (state == S_SEND) && (phase == P_LED) && (cnt == '0);
            if (fetch_q) pix_q <= pix_data;
        end
    end

    always_comb begin
        spi.spi_data = 8'h00;
        case (phase)
            P_LED: begin
                case (cnt[1:0])
                    2'd0:    spi.spi_data = {3'b111, bri_q};
                    2'd1:    spi.spi_data = pix_q[7:0];
                    2'd2:    spi.spi_data = pix_q[15:8];
                    default: spi.spi_data = pix_q[23:16];
                endcase
            end
            P_END:   spi.spi_data = 8'hFF;
            default: spi.spi_data = 8'h00;
        endcase
    end

    assign spi.spi_start = (state == S_SEND);
    assign spi.spi_size  = 4'd8;
    assign busy          = (state != S_IDLE);
endmodule
